// File: rtl/bt_status_pkg.sv
// Shared types, ASCII constants and frame-byte helpers for the Bluetooth status transmitter.
// Optional even parity (8E1) is enabled with the BT_STATUS_TX_PARITY_EN macro.
package bt_status_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef BT_STATUS_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_e;

    typedef enum logic {
        SEQ_IDLE,
        SEQ_SEND
    } seq_state_e;

    typedef struct packed {
        logic       caught;
        logic       get;
        logic       show;
        logic [3:0] photo;
        logic       sd_init;
        logic       cam_init;
    } status_t;

    localparam int FRAME_LEN = 6;

    localparam logic [7:0] ASCII_M     = 8'h4D;
    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_G     = 8'h47;
    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_I     = 8'h49;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] v);
        if (v < 4'd10) begin
            return ASCII_ZERO + {4'h0, v};
        end
        // 'A' (0x41) minus 10
        return 8'h37 + {4'h0, v};
    endfunction

    function automatic logic [7:0] mode_char(input status_t s);
        if (s.caught) begin
            return ASCII_C;
        end
        if (s.get) begin
            return ASCII_G;
        end
        if (s.show) begin
            return ASCII_S;
        end
        return ASCII_I;
    endfunction

    function automatic logic [7:0] frame_byte(input status_t s, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = ASCII_M;
            3'd1:    b = mode_char(s);
            3'd2:    b = hex_to_ascii(s.photo);
            3'd3:    b = ASCII_ZERO + {6'b0, s.sd_init, s.cam_init};
            3'd4:    b = ASCII_CR;
            default: b = ASCII_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/bluetooth_status_tx_uart.sv
// Single-byte UART serialiser: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Parity stage exists only when BT_STATUS_TX_PARITY_EN is defined.
module uart_byte_tx
    import bt_status_pkg::*;
#(
    parameter int BIT_CYC = 10416
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       done_o,
    output logic       txd_o
);

    localparam int CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CYC - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             txd_q, txd_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_MAX);
    assign txd_o   = txd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
        end
    end

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves one unassigned (no latches).
        state_d   = state_q;
        cnt_d     = bit_end ? '0 : cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        done_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_i) begin
                    state_d   = ST_START;
                    shift_d   = byte_i;
                    parity_d  = ^byte_i;
                    bit_idx_d = '0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef BT_STATUS_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef BT_STATUS_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    done_o = 1'b1;
                    // Back-to-back load keeps bytes of a frame gapless
                    if (start_i) begin
                        state_d   = ST_START;
                        shift_d   = byte_i;
                        parity_d  = ^byte_i;
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // NOTE: line level is decoded from next state and registered, so the pin never glitches.
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
`ifdef BT_STATUS_TX_PARITY_EN
            ST_PARITY: txd_d = parity_d;
`endif
            default:   txd_d = 1'b1;
        endcase
    end

endmodule

// File: rtl/bluetooth_status_tx.sv
// Status-frame transmitter: detects changes of the camera status word and sends "M<mode><photo><flags>\r\n".
// Define BT_STATUS_TX_PARITY_EN for 8E1 framing instead of 8N1.
module bluetooth_status_tx
    import bt_status_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       camera_show_mode,
    input  logic       caught_photo_mode,
    input  logic       get_photo_mode,
    input  logic [3:0] select_photo_no,
    input  logic       sd_init_done,
    input  logic       camera_init_done,
    output logic       bluetooth_txd_out,
    output logic       tx_busy
);

    localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;

    status_t    status_cur;
    status_t    prev_q;
    status_t    snap_q, snap_d;
    seq_state_e seq_q, seq_d;
    logic       pending_q, pending_d;
    logic [2:0] byte_idx_q, byte_idx_d;
    logic       byte_start;
    logic [7:0] tx_byte;
    logic       byte_done;

    assign status_cur = {caught_photo_mode, get_photo_mode, camera_show_mode,
                         select_photo_no, sd_init_done, camera_init_done};
    assign tx_busy    = (seq_q == SEQ_SEND);

    // NOTE: prev has no reset on purpose; it keeps tracking the inputs while reset is held,
    // so release never sees a false change and exactly one post-reset frame goes out.
    always_ff @(posedge sys_clk) begin
        prev_q <= status_cur;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            seq_q      <= SEQ_IDLE;
            pending_q  <= 1'b1;
            byte_idx_q <= '0;
            snap_q     <= '0;
        end else begin
            seq_q      <= seq_d;
            pending_q  <= pending_d;
            byte_idx_q <= byte_idx_d;
            snap_q     <= snap_d;
        end
    end

    always_comb begin
        seq_d      = seq_q;
        pending_d  = pending_q;
        byte_idx_d = byte_idx_q;
        snap_d     = snap_q;
        byte_start = 1'b0;
        tx_byte    = frame_byte(snap_q, byte_idx_q);

        case (seq_q)
            SEQ_IDLE: begin
                if (pending_q) begin
                    seq_d      = SEQ_SEND;
                    pending_d  = 1'b0;
                    snap_d     = status_cur;
                    byte_idx_d = '0;
                    byte_start = 1'b1;
                    tx_byte    = frame_byte(status_cur, 3'd0);
                end
            end
            SEQ_SEND: begin
                if (byte_done) begin
                    if (byte_idx_q < 3'(FRAME_LEN - 1)) begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        byte_start = 1'b1;
                        tx_byte    = frame_byte(snap_q, byte_idx_q + 3'd1);
                    end else begin
                        seq_d = SEQ_IDLE;
                    end
                end
            end
            default: seq_d = SEQ_IDLE;
        endcase

        // Applied last so a change in the frame-start cycle wins over the clear
        if (status_cur != prev_q) begin
            pending_d = 1'b1;
        end
    end

    uart_byte_tx #(
        .BIT_CYC (BIT_CYC)
    ) u_uart_byte_tx (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .start_i (byte_start),
        .byte_i  (tx_byte),
        .done_o  (byte_done),
        .txd_o   (bluetooth_txd_out)
    );

endmodule
